// File: rtl/minrv32_ifetch_if.sv
// ---------------------------------------------------------------------------
// minrv32_ifetch_if
//  Instruction-memory request bus between the minrv32 fetch stage and imem.
//  valid  : request present (held with addr until ready)
//  addr   : word address of the request, bits[1:0] always 0
//  ready  : request accepted; rdata is valid in the same cycle
//  rdata  : instruction word returned by imem
//  master : fetch-stage side, slave : memory side
// ---------------------------------------------------------------------------
interface minrv32_ifetch_if;
   logic        valid;
   logic [31:0] addr;
   logic        ready;
   logic [31:0] rdata;

   modport master (output valid, output addr, input ready, input rdata);
   modport slave  (input valid, input addr, output ready, output rdata);
endinterface

// File: rtl/minrv32_ifetch.sv
// ---------------------------------------------------------------------------
// minrv32_ifetch
//  Instruction fetch stage in front of the minrv32 single-cycle core. Owns
//  the pc, fetches over a valid/ready imem port and presents one instruction
//  at a time. An optional one-entry sequential prefetch buffer hides imem
//  latency on straight-line code.
//  Ports:
//   clk, resetn        clock / asynchronous active-low reset
//   pc, insn           current instruction and its address (NOP when invalid)
//   insn_valid         insn holds the fetched word at pc
//   step, pc_next      core commits insn and supplies the following pc
//   fetch_fault        sticky misaligned-pc_next indication
//   imem               instruction-memory request bus (master side)
//  PROGADDR_RESET must be word aligned.
// ---------------------------------------------------------------------------
module minrv32_ifetch #(
   parameter logic [31:0] PROGADDR_RESET  = 32'h0000_0000,
   parameter int          ENABLE_PREFETCH = 1,
   parameter logic [31:0] NOP_INSN        = 32'h0000_0013
) (
   input  logic             clk,
   input  logic             resetn,
   output logic [31:0]      pc,
   output logic [31:0]      insn,
   output logic             insn_valid,
   input  logic             step,
   input  logic [31:0]      pc_next,
   output logic             fetch_fault,
   minrv32_ifetch_if.master imem
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      READY = 2'd1,
      DRAIN = 2'd2,
      FAULT = 2'd3
   } state_t;

   localparam logic PF_ON = (ENABLE_PREFETCH != 0) ? 1'b1 : 1'b0;

   state_t      state_r;
   logic [31:0] pc_r;
   logic [31:0] insn_r;
   logic        insn_valid_r;
   logic        fault_r;
   logic        req_valid_r;
   logic [31:0] req_addr_r;
   logic        pf_full_r;
   logic [31:0] pf_data_r;
   logic [31:0] pf_addr_r;

   logic        grant_s;
   logic [31:0] next_plus4_s;

   // Handshake completion and the sequential successor of the incoming pc_next.
   assign grant_s      = req_valid_r & imem.ready;
   assign next_plus4_s = pc_next + 32'd4;

   // Fetch FSM: pc, current instruction, prefetch buffer and the imem request.
   // The request registers are always loaded together with the state they
   // belong to, so imem.valid/addr stay constant until the grant cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r      <= FETCH;
         pc_r         <= PROGADDR_RESET;
         insn_r       <= NOP_INSN;
         insn_valid_r <= 1'b0;
         fault_r      <= 1'b0;
         req_valid_r  <= 1'b0;
         req_addr_r   <= PROGADDR_RESET;
         pf_full_r    <= 1'b0;
         pf_data_r    <= 32'h0000_0000;
         pf_addr_r    <= 32'h0000_0000;
      end else begin
         case (state_r)
            FETCH: begin
               if (!req_valid_r) begin
                  // request is raised one cycle after reset release
                  req_valid_r <= 1'b1;
                  req_addr_r  <= pc_r;
               end else if (imem.ready) begin
                  insn_r       <= imem.rdata;
                  insn_valid_r <= 1'b1;
                  state_r      <= READY;
                  req_valid_r  <= PF_ON;
                  req_addr_r   <= pc_r + 32'd4;
               end else begin
                  state_r <= FETCH;
               end
            end
            READY: begin
               if (step) begin
                  pc_r <= pc_next;
                  if (pc_next[1:0] != 2'b00) begin
                     state_r      <= FAULT;
                     fault_r      <= 1'b1;
                     insn_r       <= NOP_INSN;
                     insn_valid_r <= 1'b0;
                     req_valid_r  <= 1'b0;
                     pf_full_r    <= 1'b0;
                  end else if (pf_full_r && (pc_next == pf_addr_r)) begin
                     insn_r      <= pf_data_r;
                     pf_full_r   <= 1'b0;
                     req_valid_r <= PF_ON;
                     req_addr_r  <= next_plus4_s;
                  end else if (grant_s && (pc_next == req_addr_r)) begin
                     // prefetch lands in the very cycle it is needed
                     insn_r      <= imem.rdata;
                     pf_full_r   <= 1'b0;
                     req_valid_r <= PF_ON;
                     req_addr_r  <= next_plus4_s;
                  end else if (req_valid_r && !imem.ready) begin
                     // request must run to completion before anything else
                     state_r      <= DRAIN;
                     insn_r       <= NOP_INSN;
                     insn_valid_r <= 1'b0;
                  end else begin
                     state_r      <= FETCH;
                     insn_r       <= NOP_INSN;
                     insn_valid_r <= 1'b0;
                     pf_full_r    <= 1'b0;
                     req_valid_r  <= 1'b1;
                     req_addr_r   <= pc_next;
                  end
               end else if (grant_s) begin
                  pf_full_r   <= 1'b1;
                  pf_data_r   <= imem.rdata;
                  pf_addr_r   <= req_addr_r;
                  req_valid_r <= 1'b0;
               end else begin
                  state_r <= READY;
               end
            end
            DRAIN: begin
               if (grant_s) begin
                  if (pc_r == req_addr_r) begin
                     state_r      <= READY;
                     insn_r       <= imem.rdata;
                     insn_valid_r <= 1'b1;
                     req_valid_r  <= PF_ON;
                     req_addr_r   <= pc_r + 32'd4;
                  end else begin
                     state_r     <= FETCH;
                     req_valid_r <= 1'b1;
                     req_addr_r  <= pc_r;
                  end
               end else begin
                  state_r <= DRAIN;
               end
            end
            FAULT: begin
               state_r <= FAULT;
            end
            default: begin
               state_r      <= FAULT;
               fault_r      <= 1'b1;
               insn_r       <= NOP_INSN;
               insn_valid_r <= 1'b0;
               req_valid_r  <= 1'b0;
            end
         endcase
      end
   end

   assign pc          = pc_r;
   assign insn        = insn_r;
   assign insn_valid  = insn_valid_r;
   assign fetch_fault = fault_r;
   assign imem.valid  = req_valid_r;
   assign imem.addr   = req_addr_r;

endmodule

// File: tb/tb_minrv32_ifetch.sv
// ---------------------------------------------------------------------------
// tb_minrv32_ifetch
//  Bench for minrv32_ifetch. Two instances share all inputs: u_pf with
//  prefetch enabled (reset pc 0), u_np without prefetch (reset pc 0x1000);
//  'sel' chooses whose outputs the core/memory models observe. A scoreboard
//  queue holds the expected (pc, insn) pairs pushed as the core model picks
//  each pc_next and popped on every committing cycle.
// ---------------------------------------------------------------------------
module tb_minrv32_ifetch;

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] RST_NP   = 32'h0000_1000;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] insn;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        step = 1'b0;
   logic [31:0] pc_next = 32'h0;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        sel = 1'b0;

   logic [31:0] pc_pf, insn_pf, pc_np, insn_np;
   logic        iv_pf, iv_np, fault_pf, fault_np;

   minrv32_ifetch_if bus_pf();
   minrv32_ifetch_if bus_np();

   assign bus_pf.ready = mem_ready;
   assign bus_pf.rdata = mem_rdata;
   assign bus_np.ready = mem_ready;
   assign bus_np.rdata = mem_rdata;

   minrv32_ifetch #(.PROGADDR_RESET(32'h0000_0000), .ENABLE_PREFETCH(1), .NOP_INSN(NOP)) u_pf (
      .clk(clk), .resetn(resetn), .pc(pc_pf), .insn(insn_pf), .insn_valid(iv_pf),
      .step(step), .pc_next(pc_next), .fetch_fault(fault_pf), .imem(bus_pf)
   );

   minrv32_ifetch #(.PROGADDR_RESET(RST_NP), .ENABLE_PREFETCH(0), .NOP_INSN(NOP)) u_np (
      .clk(clk), .resetn(resetn), .pc(pc_np), .insn(insn_np), .insn_valid(iv_np),
      .step(step), .pc_next(pc_next), .fetch_fault(fault_np), .imem(bus_np)
   );

   logic [31:0] o_pc, o_insn, o_iaddr;
   logic        o_iv, o_fault, o_ivalid;
   assign o_pc     = sel ? pc_np       : pc_pf;
   assign o_insn   = sel ? insn_np     : insn_pf;
   assign o_iv     = sel ? iv_np       : iv_pf;
   assign o_fault  = sel ? fault_np    : fault_pf;
   assign o_ivalid = sel ? bus_np.valid : bus_pf.valid;
   assign o_iaddr  = sel ? bus_np.addr  : bus_pf.addr;

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   exp_t        sb_q[$];
   logic        step_en = 1'b1;
   logic        rdy = 1'b1;
   logic        rnd_stall = 1'b0;
   logic [31:0] br_at = 32'hFFFF_FFFF;
   logic [31:0] br_to = 32'h0;
   logic [31:0] hold_pc = 32'hFFFF_FFFF;
   logic        held = 1'b0;
   logic        prev_pend = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   logic        seen_valid = 1'b0;
   logic        want_first = 1'b0;
   logic [31:0] first_exp = 32'h0;
   int          bubbles = 0;
   int          grants = 0;
   int          grants_c = 0;
   int          accepted = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BD3;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] a);
      exp_t e;
      e.pc   = a;
      e.insn = mem_word(a);
      sb_q.push_back(e);
   endtask

   // One cycle: called at a negedge, drives inputs, returns at the next negedge.
   task automatic tick();
      exp_t e;
      logic [31:0] np;
      if (prev_pend) begin
         check_val("req_hold_valid", {31'd0, o_ivalid}, 32'd1);
         check_val("req_hold_addr", o_iaddr, prev_addr);
      end
      if (o_ivalid) check_val("req_align", {30'd0, o_iaddr[1:0]}, 32'd0);
      mem_ready = rnd_stall ? ($urandom_range(0, 2) != 0) : rdy;
      mem_rdata = mem_word(o_iaddr);
      if (o_ivalid && mem_ready) begin
         grants++;
         if (o_iaddr == 32'h0000_000C) grants_c++;
         if (want_first) begin
            check_val("first_req_addr", o_iaddr, first_exp);
            want_first = 1'b0;
         end
      end
      prev_pend = o_ivalid && !mem_ready;
      prev_addr = o_iaddr;
      if (o_iv) seen_valid = 1'b1;
      else begin
         if (seen_valid) bubbles++;
         check_val("nop_when_invalid", o_insn, NOP);
      end
      pc_next = $urandom;
      step = o_iv ? 1'b0 : 1'($urandom_range(0, 1));
      if (o_iv && step_en) begin
         if (o_pc == hold_pc && !held) begin
            held = 1'b1;
         end else begin
            np = (o_pc == br_at) ? br_to : o_pc + 32'd4;
            step = 1'b1;
            pc_next = np;
            accepted++;
            if (sb_q.size() == 0) begin
               check_val("sb_underflow", o_pc, 32'hDEAD_DEAD);
            end else begin
               e = sb_q.pop_front();
               check_val("pc", o_pc, e.pc);
               check_val("insn", o_insn, e.insn);
            end
            if (np[1:0] == 2'b00) push_exp(np);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_stats(input logic [31:0] rpc);
      sb_q.delete();
      push_exp(rpc);
      prev_pend = 1'b0; seen_valid = 1'b0; held = 1'b0;
      bubbles = 0; grants = 0; grants_c = 0; accepted = 0;
   endtask

   // Synchronous-style reset pulse with reset-state checks; called at a negedge.
   task automatic do_reset(input logic [31:0] rpc);
      resetn = 1'b0; step = 1'b0; mem_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      check_val("rst_pc", o_pc, rpc);
      check_val("rst_insn_valid", {31'd0, o_iv}, 32'd0);
      check_val("rst_fault", {31'd0, o_fault}, 32'd0);
      check_val("rst_imem_valid", {31'd0, o_ivalid}, 32'd0);
      check_val("rst_insn", o_insn, NOP);
      clear_stats(rpc);
      resetn = 1'b1;
   endtask

   // Reset asserted between clock edges while a request is stalled.
   task automatic async_reset_mid_request(input logic [31:0] rpc);
      int guard;
      rdy = 1'b0; rnd_stall = 1'b0;
      guard = 0;
      while (!o_ivalid && guard < 20) begin tick(); guard++; end
      check_val("async_setup_req", {31'd0, o_ivalid}, 32'd1);
      #2 resetn = 1'b0;
      #1;
      check_val("async_imem_valid", {31'd0, o_ivalid}, 32'd0);
      check_val("async_pc", o_pc, rpc);
      check_val("async_insn_valid", {31'd0, o_iv}, 32'd0);
      @(negedge clk);
      clear_stats(rpc);
      resetn = 1'b1;
      want_first = 1'b1;
      first_exp = rpc;
      rdy = 1'b1;
   endtask

   initial begin
      int guard;
      @(negedge clk);
      // T1: straight-line code, zero-wait memory
      sel = 1'b0;
      do_reset(32'h0);
      for (int i = 0; i < 16; i++) tick();
      check_val("t1_bubbles", bubbles, 32'd0);
      check_val("t1_req_per_insn", grants, accepted + 1);

      // T2: jump at 0x8 to 0x100 with 0xC sitting in the prefetch buffer
      do_reset(32'h0);
      br_at = 32'h8; br_to = 32'h100; hold_pc = 32'h8;
      for (int i = 0; i < 12; i++) tick();
      check_val("t2_bubbles", bubbles, 32'd1);
      check_val("t2_req_0xc_once", grants_c, 32'd1);
      br_at = 32'hFFFF_FFFF; hold_pc = 32'hFFFF_FFFF;

      // T3: prefetch stalled 5 cycles, step during the stall -> DRAIN
      do_reset(32'h0);
      guard = 0;
      while (!(o_iv && o_pc == 32'h10) && guard < 20) begin tick(); guard++; end
      check_val("t3_reach_0x10", o_pc, 32'h10);
      rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_val("t3_drain_invalid", {31'd0, o_iv}, 32'd0);
      end
      rdy = 1'b1;
      tick();
      check_val("t3_valid_after_ready", {31'd0, o_iv}, 32'd1);
      check_val("t3_insn", o_insn, mem_word(32'h14));
      check_val("t3_pc", o_pc, 32'h14);
      for (int i = 0; i < 4; i++) tick();

      // T4: misaligned pc_next -> sticky fault
      do_reset(32'h0);
      br_at = 32'h8; br_to = 32'h102;
      guard = 0;
      while (!o_fault && guard < 20) begin tick(); guard++; end
      for (int i = 0; i < 3; i++) begin
         check_val("t4_fault", {31'd0, o_fault}, 32'd1);
         check_val("t4_imem_valid", {31'd0, o_ivalid}, 32'd0);
         check_val("t4_insn", o_insn, NOP);
         check_val("t4_pc", o_pc, 32'h102);
         tick();
      end

      // T6: wrap from 0xFFFF_FFFC to 0
      do_reset(32'h0);
      br_at = 32'h4; br_to = 32'hFFFF_FFFC;
      guard = 0;
      while (!(o_iv && o_pc == 32'hFFFF_FFFC) && guard < 20) begin tick(); guard++; end
      check_val("t6_at_top", o_pc, 32'hFFFF_FFFC);
      check_val("t6_prefetch_wrap", o_iaddr, 32'h0);
      for (int i = 0; i < 4; i++) tick();
      br_at = 32'hFFFF_FFFF;

      // T5: async reset mid-request, prefetch instance
      rdy = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      async_reset_mid_request(32'h0);
      for (int i = 0; i < 8; i++) tick();

      // T5 repeat: no-prefetch instance, random stalls, loop in 0x1000..0x1010
      sel = 1'b1;
      do_reset(RST_NP);
      async_reset_mid_request(RST_NP);
      br_at = 32'h1010; br_to = RST_NP;
      rnd_stall = 1'b1;
      for (int i = 0; i < 80; i++) tick();
      rnd_stall = 1'b0;
      check_val("t5_np_progress", {31'd0, 1'(accepted > 5)}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
